kiwih_tt_top: RTL and testbench

KIWIH_TT_TOP -- requirements
Module: kiwih_tt_top

---
 rtl/kiwih_tt_top_pkg.sv | 54 +++++
 rtl/kiwih_tt_top_scan_reg.sv | 26 ++
 rtl/kiwih_tt_top.sv | 133 +++++++++++++
 tb/tb_kiwih_tt_top.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kiwih_tt_top_pkg.sv
// Shared constants, state encodings and opcodes for the scan-chain accumulator CPU.
// The bus_read helper is the single definition of the 32-entry address map.
package kiwih_tt_top_pkg;
   localparam int         CHAIN_LEN = 160;
   localparam int         MEM_BYTES = 16;
   localparam logic [4:0] IO_ADDR   = 5'd16;

   typedef enum logic [2:0] {
      ST_FETCH = 3'b001,
      ST_EXEC  = 3'b010,
      ST_HALT  = 3'b100
   } state_e;

   typedef enum logic [2:0] {
      OP_LDA = 3'd0,
      OP_STA = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_EXT = 3'd7
   } op_e;

   // Low nibble of the 0xFx extended instructions
   localparam logic [3:0] X_JMP  = 4'h0;
   localparam logic [3:0] X_JSR  = 4'h1;
   localparam logic [3:0] X_BEQF = 4'h2;
   localparam logic [3:0] X_BEQB = 4'h3;
   localparam logic [3:0] X_BNEF = 4'h4;
   localparam logic [3:0] X_BNEB = 4'h5;
   localparam logic [3:0] X_SHL  = 4'h6;
   localparam logic [3:0] X_SHR  = 4'h7;
   localparam logic [3:0] X_SHL4 = 4'h8;
   localparam logic [3:0] X_ROL  = 4'h9;
   localparam logic [3:0] X_ROR  = 4'hA;
   localparam logic [3:0] X_LDAR = 4'hB;
   localparam logic [3:0] X_DEC  = 4'hC;
   localparam logic [3:0] X_CLR  = 4'hD;
   localparam logic [3:0] X_INV  = 4'hE;
   localparam logic [7:0] I_HLT  = 8'hFF;

   function automatic logic [7:0] bus_read(input logic [4:0]                 addr,
                                           input logic [MEM_BYTES-1:0][7:0] mem,
                                           input logic [7:0]                 io);
      logic [7:0] r;
      r = 8'h00;
      if (!addr[4])
         r = mem[addr[3:0]];
      else if (addr == IO_ADDR)
         r = io;
      return r;
   endfunction
endpackage

// File: rtl/kiwih_tt_top_scan_reg.sv
// Scannable register: reset to RST_VAL, else shift one bit in at the LSB, else load d_i, else hold.
module scan_reg #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         shift_i,
   input  logic         load_i,
   input  logic         scan_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         q_q <= RST_VAL;
      else if (shift_i)
         q_q <= {q_q[W-2:0], scan_i};
      else if (load_i)
         q_q <= d_i;
   end

   assign q_o = q_q;
endmodule

// File: rtl/kiwih_tt_top.sv
// 8-bit accumulator CPU whose entire state is one 160-bit scan chain; every instruction
// is a FETCH cycle followed by an EXEC cycle, and scan mode freezes execution.
module kiwih_tt_top
   import kiwih_tt_top_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);
   logic clk, rst, scan_mode, run, scan_in, btn;
   logic unused_io;

   assign clk       = io_in[0];
   assign rst       = io_in[1];
   assign scan_mode = ~io_in[2];
   assign run       = ~io_in[3] & io_in[2];
   assign scan_in   = io_in[4];
   assign btn       = io_in[5];
   assign unused_io = &{1'b0, io_in[7:6]};

   logic [2:0]                 state_q, state_d;
   logic [4:0]                 pc_q, pc_d;
   logic [7:0]                 ir_q, ir_d, acc_q, acc_d, io_q, io_d;
   logic [MEM_BYTES-1:0][7:0]  mem_q;
   logic [MEM_BYTES-1:0]       mem_sin;
   logic                       mem_we;
   logic [3:0]                 mem_wa;
   logic [7:0]                 fetch_dat, operand, ind_dat;

   assign fetch_dat = bus_read(pc_q, mem_q, io_q);
   assign operand   = bus_read(ir_q[4:0], mem_q, io_q);
   assign ind_dat   = bus_read(acc_q[4:0], mem_q, io_q);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      io_d    = {io_q[7:1], btn};
      mem_we  = 1'b0;
      mem_wa  = ir_q[3:0];
      if (run) begin
         case (state_q)
            ST_FETCH: begin
               ir_d    = fetch_dat;
               pc_d    = pc_q + 5'd1;
               state_d = ST_EXEC;
            end
            ST_EXEC: begin
               state_d = (ir_q == I_HLT) ? ST_HALT : ST_FETCH;
               case (ir_q[7:5])
                  OP_LDA: acc_d = operand;
                  OP_STA: begin
                     // IO[0] always follows the button, so only IO[7:1] is writable
                     if (!ir_q[4])
                        mem_we = 1'b1;
                     else if (ir_q[4:0] == IO_ADDR)
                        io_d = {acc_q[7:1], btn};
                  end
                  OP_ADD: acc_d = acc_q + operand;
                  OP_SUB: acc_d = acc_q - operand;
                  OP_AND: acc_d = acc_q & operand;
                  OP_OR:  acc_d = acc_q | operand;
                  OP_XOR: acc_d = acc_q ^ operand;
                  OP_EXT: begin
                     if (!ir_q[4]) begin
                        acc_d = acc_q + {4'h0, ir_q[3:0]};
                     end else begin
                        case (ir_q[3:0])
                           X_JMP:  pc_d = acc_q[4:0];
                           X_JSR:  begin
                              acc_d = {3'b000, pc_q};
                              pc_d  = acc_q[4:0];
                           end
                           X_BEQF: if (acc_q == 8'h00) pc_d = pc_q + 5'd2;
                           X_BEQB: if (acc_q == 8'h00) pc_d = pc_q - 5'd3;
                           X_BNEF: if (acc_q != 8'h00) pc_d = pc_q + 5'd2;
                           X_BNEB: if (acc_q != 8'h00) pc_d = pc_q - 5'd3;
                           X_SHL:  acc_d = acc_q << 1;
                           X_SHR:  acc_d = acc_q >> 1;
                           X_SHL4: acc_d = acc_q << 4;
                           X_ROL:  acc_d = {acc_q[6:0], acc_q[7]};
                           X_ROR:  acc_d = {acc_q[0], acc_q[7:1]};
                           X_LDAR: acc_d = ind_dat;
                           X_DEC:  acc_d = acc_q - 8'd1;
                           X_CLR:  acc_d = 8'h00;
                           X_INV:  acc_d = ~acc_q;
                           default: ;
                        endcase
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Chain order from bit 0 upward: STATE, PC, IR, ACC, MEM0..MEM15, IO
   scan_reg #(.W(3), .RST_VAL(ST_FETCH)) u_state (
      .clk_i(clk), .rst_i(rst), .shift_i(scan_mode), .load_i(run),
      .scan_i(scan_in), .d_i(state_d), .q_o(state_q));

   scan_reg #(.W(5)) u_pc (
      .clk_i(clk), .rst_i(rst), .shift_i(scan_mode), .load_i(run),
      .scan_i(state_q[2]), .d_i(pc_d), .q_o(pc_q));

   scan_reg #(.W(8)) u_ir (
      .clk_i(clk), .rst_i(rst), .shift_i(scan_mode), .load_i(run),
      .scan_i(pc_q[4]), .d_i(ir_d), .q_o(ir_q));

   scan_reg #(.W(8)) u_acc (
      .clk_i(clk), .rst_i(rst), .shift_i(scan_mode), .load_i(run),
      .scan_i(ir_q[7]), .d_i(acc_d), .q_o(acc_q));

   for (genvar k = 0; k < MEM_BYTES; k++) begin : g_mem
      if (k == 0) begin : g_first
         assign mem_sin[k] = acc_q[7];
      end else begin : g_next
         assign mem_sin[k] = mem_q[k-1][7];
      end
      scan_reg #(.W(8)) u_mem (
         .clk_i(clk), .rst_i(rst), .shift_i(scan_mode),
         .load_i(run && mem_we && (mem_wa == 4'(k))),
         .scan_i(mem_sin[k]), .d_i(acc_q), .q_o(mem_q[k]));
   end

   scan_reg #(.W(8)) u_io (
      .clk_i(clk), .rst_i(rst), .shift_i(scan_mode), .load_i(1'b1),
      .scan_i(mem_q[MEM_BYTES-1][7]), .d_i(io_d), .q_o(io_q));

   assign io_out = {(scan_mode ? io_q[7] : (state_q == ST_HALT)), io_q[7:1]};
endmodule

// File: tb/tb_kiwih_tt_top.sv
// Scoreboard bench: expected chain fields are queued when a program is set up and
// popped against the scanned-out chain.
module tb_kiwih_tt_top;
   logic clk = 1'b0, rst = 1'b0, sen_n = 1'b1, pen_n = 1'b1, sin = 1'b0, btn = 1'b0;
   logic [7:0] io_in, io_out;

   assign io_in = {2'b00, btn, sin, pen_n, sen_n, rst, clk};

   kiwih_tt_top dut (.io_in(io_in), .io_out(io_out));

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         lo;
      int         w;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [159:0] image(input logic [2:0] st, input logic [4:0] pc,
                                          input logic [7:0] ir, input logic [7:0] acc,
                                          input logic [15:0][7:0] mem, input logic [7:0] io);
      return {io, mem, acc, ir, pc, st};
   endfunction

   task automatic expect_field(input string n, input int lo, input int w, input logic [7:0] v);
      sb.push_back('{n, lo, w, v});
   endtask

   task automatic expect_mem(input int k, input logic [7:0] v);
      expect_field($sformatf("mem%0d", k), 24 + 8 * k, 8, v);
   endtask

   task automatic expect_reset_image();
      expect_field("state", 0, 3, 8'h01);
      expect_field("pc", 3, 5, 8'h00);
      expect_field("ir", 8, 8, 8'h00);
      expect_field("acc", 16, 8, 8'h00);
      expect_field("io", 152, 8, 8'h00);
      for (int k = 0; k < 16; k++) expect_mem(k, 8'h00);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic scan_xfer(input logic [159:0] din, output logic [159:0] dout);
      dout = '0;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         sen_n = 1'b0;
         sin   = din[159-i];
         #1;
         dout[159-i] = io_out[7];
      end
      @(negedge clk);
      sen_n = 1'b1;
   endtask

   task automatic run_cycles(input int n);
      @(negedge clk);
      pen_n = 1'b0;
      repeat (n) @(negedge clk);
      pen_n = 1'b1;
   endtask

   task automatic run_until_halt(input int limit, output bit halted);
      halted = 1'b0;
      @(negedge clk);
      pen_n = 1'b0;
      for (int i = 0; i < limit && !halted; i++) begin
         @(negedge clk);
         halted = io_out[7];
      end
      pen_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [159:0] dout;
      exp_t e;
      logic [7:0] got;
      reset_dut();
      #1;
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_io_out: got %h expected 00", io_out);
      end
      expect_reset_image();
      scan_xfer('0, dout);
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         got = 8'((dout >> e.lo) & ((160'd1 << e.w) - 160'd1));
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL reset_%s: got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   task automatic load_demo();
      logic [159:0] dout;
      logic [15:0][7:0] m;
      m = '0;
      for (int k = 0; k < 5; k++) m[k] = 8'hE0 + 8'(k);
      reset_dut();
      scan_xfer(image(3'b001, 5'd1, 8'h00, 8'h01, m, 8'hF0), dout);
   endtask

   task automatic test_scan_load();
      load_demo();
      #1;
      checks++;
      if (io_out !== 8'h78) begin
         errors++;
         $display("FAIL scan_led: got %h expected 78", io_out);
      end
   endtask

   task automatic test_run();
      logic [159:0] dout;
      exp_t e;
      logic [7:0] got;
      load_demo();
      expect_field("state", 0, 3, 8'h01);
      expect_field("pc", 3, 5, 8'h05);
      expect_field("ir", 8, 8, 8'hE4);
      expect_field("acc", 16, 8, 8'h0B);
      expect_field("io", 152, 8, 8'hF0);
      for (int k = 0; k < 5; k++) expect_mem(k, 8'hE0 + 8'(k));
      run_cycles(4);
      repeat (3) @(negedge clk);
      run_cycles(4);
      scan_xfer('0, dout);
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         got = 8'((dout >> e.lo) & ((160'd1 << e.w) - 160'd1));
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL run_%s: got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   task automatic test_halt_loop();
      logic [159:0] dout;
      logic [15:0][7:0] m;
      logic [0:11][7:0] prog;
      exp_t e;
      logic [7:0] got;
      bit halted;
      prog = {8'h0F, 8'hF2, 8'hFC, 8'h2F, 8'hF5, 8'hEF, 8'hF8, 8'hEF, 8'hE1, 8'h2E, 8'hF3, 8'hFF};
      m = '0;
      for (int k = 0; k < 12; k++) m[k] = prog[k];
      m[15] = 8'h10;
      reset_dut();
      scan_xfer(image(3'b001, 5'd0, 8'h00, 8'h00, m, 8'h00), dout);
      expect_field("state", 0, 3, 8'h04);
      expect_mem(15, 8'h00);
      expect_mem(14, 8'h01);
      run_until_halt(256, halted);
      checks++;
      if (!halted) begin
         errors++;
         $display("FAIL loop_halt: halt=%b expected 1 within 256 cycles", halted);
      end
      scan_xfer('0, dout);
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         got = 8'((dout >> e.lo) & ((160'd1 << e.w) - 160'd1));
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL loop_%s: got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   task automatic test_alu();
      logic [159:0] dout;
      logic [15:0][7:0] m;
      logic [0:15][7:0] prog;
      logic [0:5][7:0] res;
      exp_t e;
      logic [7:0] got;
      bit halted;
      prog = {8'h10, 8'hE1, 8'h20, 8'h50, 8'h21, 8'h70, 8'h22, 8'h8F,
              8'h23, 8'hAE, 8'h24, 8'hCD, 8'h25, 8'hFF, 8'h04, 8'h0F};
      res  = {8'd11, 8'd21, 8'd11, 8'd11, 8'd15, 8'hF0};
      for (int k = 0; k < 16; k++) m[k] = prog[k];
      reset_dut();
      scan_xfer(image(3'b001, 5'd0, 8'h00, 8'h00, m, 8'h0A), dout);
      for (int k = 0; k < 6; k++) expect_mem(k, res[k]);
      expect_field("acc", 16, 8, 8'hF0);
      expect_field("state", 0, 3, 8'h04);
      expect_field("io_btn", 152, 8, 8'h0B);
      run_until_halt(256, halted);
      checks++;
      if (!halted) begin
         errors++;
         $display("FAIL alu_halt: halt=%b expected 1 within 256 cycles", halted);
      end
      @(negedge clk);
      btn = 1'b1;
      scan_xfer('0, dout);
      btn = 1'b0;
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         got = 8'((dout >> e.lo) & ((160'd1 << e.w) - 160'd1));
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL alu_%s: got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   task automatic test_shift();
      logic [159:0] dout;
      logic [15:0][7:0] m;
      logic [0:15][7:0] prog;
      logic [0:6][7:0] res;
      exp_t e;
      logic [7:0] got;
      prog = {8'h10, 8'hF6, 8'h20, 8'hF7, 8'h21, 8'hF8, 8'h22, 8'hF9,
              8'h23, 8'hFA, 8'h24, 8'hFC, 8'h25, 8'hFD, 8'hFE, 8'h26};
      res  = {8'd20, 8'd10, 8'd160, 8'd65, 8'd160, 8'd159, 8'd255};
      for (int k = 0; k < 16; k++) m[k] = prog[k];
      reset_dut();
      scan_xfer(image(3'b001, 5'd0, 8'h00, 8'h00, m, 8'h0A), dout);
      for (int k = 0; k < 7; k++) expect_mem(k, res[k]);
      expect_field("acc", 16, 8, 8'hFF);
      expect_field("pc", 3, 5, 8'd16);
      expect_field("state", 0, 3, 8'h01);
      run_cycles(32);
      scan_xfer('0, dout);
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         got = 8'((dout >> e.lo) & ((160'd1 << e.w) - 160'd1));
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL shift_%s: got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [159:0] dout;
      exp_t e;
      logic [7:0] got;
      @(negedge clk);
      sen_n = 1'b0;
      for (int i = 0; i < 70; i++) begin
         sin = 1'($urandom);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      sen_n = 1'b1;
      #1;
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL midscan_io_out: got %h expected 00", io_out);
      end
      expect_reset_image();
      scan_xfer('0, dout);
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         got = 8'((dout >> e.lo) & ((160'd1 << e.w) - 160'd1));
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL midscan_%s: got %h expected %h", e.name, got, e.val);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_scan_load();
      test_run();
      test_halt_loop();
      test_alu();
      test_shift();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
